// File: rtl/flush_sequencer_if.sv
// Flush sequencer handshake bundle: register-decode strobe, FIFO status,
// drain bus request/ack and flush status outputs.
interface flush_sequencer_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1,
  parameter int unsigned BP_W  = $clog2(WIDTH / 8)
);
  logic               FLUSH_REQ;
  logic               DMAENA;
  logic [LVL_W-1:0]   FIFO_LEVEL;
  logic [BP_W-1:0]    BYTE_PTR;
  logic               DRAIN_ACK;
  logic               DRAIN_REQ;
  logic [WIDTH/8-1:0] DRAIN_BE;
  logic               FLUSHFIFO;
  logic               FLUSH_DONE;
  logic               FLUSH_TMO;
  logic [LVL_W-1:0]   WORDS_FLUSHED;

  modport master (
    output FLUSH_REQ, DMAENA, FIFO_LEVEL, BYTE_PTR, DRAIN_ACK,
    input  DRAIN_REQ, DRAIN_BE, FLUSHFIFO, FLUSH_DONE, FLUSH_TMO, WORDS_FLUSHED
  );

  modport slave (
    input  FLUSH_REQ, DMAENA, FIFO_LEVEL, BYTE_PTR, DRAIN_ACK,
    output DRAIN_REQ, DRAIN_BE, FLUSHFIFO, FLUSH_DONE, FLUSH_TMO, WORDS_FLUSHED
  );
endinterface

// File: rtl/flush_sequencer.sv
// Actively drains the DMA FIFO on a flush strobe: one bus request per full
// entry, then a byte-enabled request for a trailing partial entry.
module flush_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned LVL_W   = $clog2(DEPTH) + 1,
  parameter int unsigned BP_W    = $clog2(WIDTH / 8)
) (
  input  logic               CLK,
  input  logic               CLR_FLUSHFIFO,
  flush_sequencer_if.slave   bus
);

  localparam int unsigned     NB       = WIDTH / 8;
  localparam logic [NB-1:0]   BE_ALL   = '1;
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

  state_t           state_q, state_d;
  logic             drain_req_q, drain_req_d;
  logic [NB-1:0]    drain_be_q, drain_be_d;
  logic             flushfifo_q, flushfifo_d;
  logic             flush_done_q, flush_done_d;
  logic             flush_tmo_q, flush_tmo_d;
  logic [LVL_W-1:0] words_q, words_d;
  logic [15:0]      timer_q, timer_d;

  always_ff @(posedge CLK or negedge CLR_FLUSHFIFO) begin
    if (!CLR_FLUSHFIFO) begin
      state_q      <= S_IDLE;
      drain_req_q  <= 1'b0;
      drain_be_q   <= '0;
      flushfifo_q  <= 1'b0;
      flush_done_q <= 1'b0;
      flush_tmo_q  <= 1'b0;
      words_q      <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      drain_req_q  <= drain_req_d;
      drain_be_q   <= drain_be_d;
      flushfifo_q  <= flushfifo_d;
      flush_done_q <= flush_done_d;
      flush_tmo_q  <= flush_tmo_d;
      words_q      <= words_d;
      timer_q      <= timer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_req_d  = drain_req_q;
    drain_be_d   = drain_be_q;
    flushfifo_d  = flushfifo_q;
    flush_done_d = 1'b0;
    flush_tmo_d  = flush_tmo_q;
    words_d      = words_q;
    timer_d      = timer_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.FLUSH_REQ) begin
          state_d     = S_ARM;
          flushfifo_d = 1'b1;
          words_d     = '0;
        end
      end
      S_ARM: state_d = S_REQ;
      S_REQ: begin
        timer_d = '0;
        if (!bus.DMAENA || (bus.FIFO_LEVEL == '0 && bus.BYTE_PTR == '0)) begin
          state_d      = S_DONE;
          flush_done_d = 1'b1;
          flushfifo_d  = 1'b0;
        end else begin
          state_d     = S_WAIT;
          drain_req_d = 1'b1;
          // Pointers past the last lane shift to zero, giving a full entry.
          drain_be_d  = (bus.FIFO_LEVEL != '0) ? BE_ALL : ~(BE_ALL >> bus.BYTE_PTR);
        end
      end
      S_WAIT: begin
        // Ack is checked before expiry so a same-cycle ack completes normally.
        if (bus.DRAIN_ACK) begin
          state_d     = S_REQ;
          drain_req_d = 1'b0;
          drain_be_d  = '0;
          timer_d     = '0;
          if (words_q != '1) words_d = words_q + 1'b1;
        end else if (timer_q == TMO_LAST) begin
          state_d     = S_ERR;
          drain_req_d = 1'b0;
          drain_be_d  = '0;
          flush_tmo_d = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.DRAIN_REQ     = drain_req_q;
  assign bus.DRAIN_BE      = drain_be_q;
  assign bus.FLUSHFIFO     = flushfifo_q;
  assign bus.FLUSH_DONE    = flush_done_q;
  assign bus.FLUSH_TMO     = flush_tmo_q;
  assign bus.WORDS_FLUSHED = words_q;

endmodule

// File: tb/tb_flush_sequencer.sv
// Randomised bench for flush_sequencer: the bench acts as FIFO and bus master
// and compares against a request-list model of the drain.
module tb_flush_sequencer;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned NB      = WIDTH / 8;
  localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;
  localparam int          WORDS_MAX = (1 << LVL_W) - 1;

  logic clk = 1'b0;
  logic clr_n;

  flush_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  flush_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK           (clk),
    .CLR_FLUSHFIFO (clr_n),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [NB-1:0] obs_be[$];
  logic [NB-1:0] exp_be[$];
  int            dly[$];
  int            done_at, done_cnt, first_req_at;
  bit            ff_at1, be_stable, ff_after_done;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected request list: one full-lane request per entry, then the partial.
  function automatic void build_expect(input int lvl, input int ptr, input int max_req);
    logic [NB-1:0] part = '0;
    exp_be.delete();
    for (int i = 0; i < lvl; i++) exp_be.push_back({NB{1'b1}});
    if (ptr != 0) begin
      for (int l = 0; l < ptr && l < int'(NB); l++) part[NB-1-l] = 1'b1;
      exp_be.push_back(part);
    end
    while (max_req >= 0 && exp_be.size() > max_req) void'(exp_be.pop_back());
  endfunction

  // Flush strobe launched before edge 1; ARM, REQ, then each request takes
  // its ack delay plus a WAIT cycle and a re-sampling REQ cycle.
  function automatic int exp_done_at();
    int t = 3;
    foreach (dly[i]) t += dly[i] + 2;
    return t;
  endfunction

  function automatic int exp_words();
    return (exp_be.size() > WORDS_MAX) ? WORDS_MAX : exp_be.size();
  endfunction

  function automatic int seq_errors();
    int e = 0;
    if (obs_be.size() != exp_be.size()) e = 1 + obs_be.size() + exp_be.size();
    else foreach (obs_be[i]) if (obs_be[i] !== exp_be[i]) e++;
    return e;
  endfunction

  // Bus-master / FIFO driver; records what the DUT requested.
  task automatic run_drain(input int min_dly, input int max_dly, input int cycles,
                           input int drop_at, input int strobe_at, input bit hold_fifo);
    int            wait_left = 0;
    bit            in_req = 1'b0;
    logic [NB-1:0] cur_be = '0;
    obs_be.delete(); dly.delete();
    done_at = -1; done_cnt = 0; first_req_at = -1;
    ff_at1 = 1'b0; be_stable = 1'b1; ff_after_done = 1'b0;
    bus.FLUSH_REQ = 1'b1;
    for (int c = 1; c <= cycles; c++) begin
      step();
      bus.FLUSH_REQ = 1'b0;
      if (c == 1) ff_at1 = bus.FLUSHFIFO;
      if (bus.DRAIN_ACK) begin
        bus.DRAIN_ACK = 1'b0;
        in_req = 1'b0;
        if (!hold_fifo) begin
          if (bus.FIFO_LEVEL != '0) bus.FIFO_LEVEL = bus.FIFO_LEVEL - 1'b1;
          else bus.BYTE_PTR = '0;
        end
      end
      if (bus.FLUSH_DONE) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && bus.FLUSHFIFO) ff_after_done = 1'b1;
      if (bus.DRAIN_REQ) begin
        if (!in_req) begin
          in_req = 1'b1;
          cur_be = bus.DRAIN_BE;
          obs_be.push_back(cur_be);
          wait_left = $urandom_range(max_dly, min_dly);
          dly.push_back(wait_left);
          if (first_req_at < 0) first_req_at = c;
          if (obs_be.size() == drop_at) bus.DMAENA = 1'b0;
          if (obs_be.size() == strobe_at) bus.FLUSH_REQ = 1'b1;
        end else if (bus.DRAIN_BE !== cur_be) begin
          be_stable = 1'b0;
        end
        if (wait_left == 0) bus.DRAIN_ACK = 1'b1;
        else wait_left--;
      end
    end
    bus.DRAIN_ACK = 1'b0;
    bus.DMAENA    = 1'b1;
  endtask

  task automatic test_reset();
    logic [NB+LVL_W+3:0] outs;
    clr_n = 1'b0;
    #12;
    outs = {bus.DRAIN_REQ, bus.DRAIN_BE, bus.FLUSHFIFO, bus.FLUSH_DONE, bus.FLUSH_TMO, bus.WORDS_FLUSHED};
    chk_cnt++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h, required 0", outs);
    else pass_cnt++;
    clr_n = 1'b1;
    step(); step();
    outs = {bus.DRAIN_REQ, bus.DRAIN_BE, bus.FLUSHFIFO, bus.FLUSH_DONE, bus.FLUSH_TMO, bus.WORDS_FLUSHED};
    chk_cnt++;
    if (outs !== '0) $display("FAIL idle_after_reset: got %h, required 0", outs);
    else pass_cnt++;
  endtask

  task automatic test_full_drain();
    bus.FIFO_LEVEL = 3; bus.BYTE_PTR = 0;
    build_expect(3, 0, -1);
    run_drain(2, 2, 20, -1, -1, 1'b0);
    chk_cnt++;
    if (ff_at1 !== 1'b1) $display("FAIL full_flushfifo_n1: got %b, required 1", ff_at1);
    else pass_cnt++;
    chk_cnt++;
    if (first_req_at != 3) $display("FAIL full_first_req: got edge %0d, required 3", first_req_at);
    else pass_cnt++;
    chk_cnt++;
    if (seq_errors() != 0) $display("FAIL full_be_seq: got %0d reqs/%0d errs, required %0d reqs/0", obs_be.size(), seq_errors(), exp_be.size());
    else pass_cnt++;
    chk_cnt++;
    if (done_at != exp_done_at() || done_cnt != 1) $display("FAIL full_done: got edge %0d x%0d, required edge %0d x1", done_at, done_cnt, exp_done_at());
    else pass_cnt++;
    chk_cnt++;
    if (ff_after_done !== 1'b0) $display("FAIL full_flushfifo_clear: got %b, required 0", ff_after_done);
    else pass_cnt++;
    chk_cnt++;
    if (int'(bus.WORDS_FLUSHED) != 3) $display("FAIL full_words: got %0d, required 3", bus.WORDS_FLUSHED);
    else pass_cnt++;
    chk_cnt++;
    if (be_stable !== 1'b1) $display("FAIL full_be_stable: got %b, required 1", be_stable);
    else pass_cnt++;
  endtask

  task automatic test_partial();
    bus.FIFO_LEVEL = 1; bus.BYTE_PTR = 2;
    build_expect(1, 2, -1);
    run_drain(2, 2, 20, -1, -1, 1'b0);
    chk_cnt++;
    if (seq_errors() != 0 || exp_be[1] !== 4'hC) $display("FAIL partial_be_seq: got %0d reqs/%0d errs, required 2 reqs F,C", obs_be.size(), seq_errors());
    else pass_cnt++;
    chk_cnt++;
    if (int'(bus.WORDS_FLUSHED) != 2) $display("FAIL partial_words: got %0d, required 2", bus.WORDS_FLUSHED);
    else pass_cnt++;
    chk_cnt++;
    if (done_at != exp_done_at()) $display("FAIL partial_done: got edge %0d, required %0d", done_at, exp_done_at());
    else pass_cnt++;
  endtask

  task automatic test_empty();
    bus.FIFO_LEVEL = 0; bus.BYTE_PTR = 0;
    run_drain(0, 0, 8, -1, -1, 1'b0);
    chk_cnt++;
    if (first_req_at != -1) $display("FAIL empty_no_req: got req at edge %0d, required none", first_req_at);
    else pass_cnt++;
    chk_cnt++;
    if (done_at != 3 || done_cnt != 1) $display("FAIL empty_done: got edge %0d x%0d, required edge 3 x1", done_at, done_cnt);
    else pass_cnt++;
    chk_cnt++;
    if (int'(bus.WORDS_FLUSHED) != 0) $display("FAIL empty_words: got %0d, required 0", bus.WORDS_FLUSHED);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int lvl = $urandom_range(DEPTH, 0);
      int ptr = $urandom_range(NB - 1, 0);
      bus.FIFO_LEVEL = LVL_W'(lvl); bus.BYTE_PTR = 2'(ptr);
      build_expect(lvl, ptr, -1);
      run_drain(0, TIMEOUT - 1, 60, -1, -1, 1'b0);
      chk_cnt++;
      if (seq_errors() != 0) $display("FAIL rand_be_seq[%0d]: got %0d reqs/%0d errs, required %0d reqs/0", it, obs_be.size(), seq_errors(), exp_be.size());
      else pass_cnt++;
      chk_cnt++;
      if (done_at != exp_done_at() || done_cnt != 1) $display("FAIL rand_done[%0d]: got edge %0d x%0d, required edge %0d x1", it, done_at, done_cnt, exp_done_at());
      else pass_cnt++;
      chk_cnt++;
      if (int'(bus.WORDS_FLUSHED) != exp_words()) $display("FAIL rand_words[%0d]: got %0d, required %0d", it, bus.WORDS_FLUSHED, exp_words());
      else pass_cnt++;
      chk_cnt++;
      if (be_stable !== 1'b1 || bus.FLUSH_TMO !== 1'b0) $display("FAIL rand_stable[%0d]: got stable=%b tmo=%b, required 1/0", it, be_stable, bus.FLUSH_TMO);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    bus.FIFO_LEVEL = 4; bus.BYTE_PTR = 0;
    build_expect(4, 0, 1);
    run_drain(1, 3, 20, 1, -1, 1'b0);
    chk_cnt++;
    if (seq_errors() != 0) $display("FAIL abort_be_seq: got %0d reqs, required 1", obs_be.size());
    else pass_cnt++;
    chk_cnt++;
    if (done_at != exp_done_at() || done_cnt != 1) $display("FAIL abort_done: got edge %0d x%0d, required edge %0d x1", done_at, done_cnt, exp_done_at());
    else pass_cnt++;
    chk_cnt++;
    if (int'(bus.WORDS_FLUSHED) != 1) $display("FAIL abort_words: got %0d, required 1", bus.WORDS_FLUSHED);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bus.FIFO_LEVEL = 2; bus.BYTE_PTR = 0;
    build_expect(2, 0, -1);
    run_drain(1, 2, 25, -1, 1, 1'b0);
    chk_cnt++;
    if (seq_errors() != 0) $display("FAIL b2b_be_seq: got %0d reqs, required 2", obs_be.size());
    else pass_cnt++;
    chk_cnt++;
    if (done_cnt != 1 || ff_after_done !== 1'b0) $display("FAIL b2b_no_requeue: got done x%0d ff_after=%b, required x1/0", done_cnt, ff_after_done);
    else pass_cnt++;
    chk_cnt++;
    if (int'(bus.WORDS_FLUSHED) != 2) $display("FAIL b2b_words: got %0d, required 2", bus.WORDS_FLUSHED);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    bus.FIFO_LEVEL = 5; bus.BYTE_PTR = 0;
    build_expect(100, 0, WORDS_MAX + 2);
    run_drain(0, 0, 50, WORDS_MAX + 2, -1, 1'b1);
    chk_cnt++;
    if (seq_errors() != 0) $display("FAIL sat_be_seq: got %0d reqs, required %0d", obs_be.size(), exp_be.size());
    else pass_cnt++;
    chk_cnt++;
    if (int'(bus.WORDS_FLUSHED) != exp_words()) $display("FAIL sat_words: got %0d, required %0d", bus.WORDS_FLUSHED, exp_words());
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int hi = 0;
    bit err_held = 1'b1;
    logic [NB+LVL_W+3:0] outs;
    bus.FIFO_LEVEL = 2; bus.BYTE_PTR = 0;
    bus.FLUSH_REQ = 1'b1;
    step();
    bus.FLUSH_REQ = 1'b0;
    for (int c = 2; c <= 20; c++) begin
      step();
      if (bus.DRAIN_REQ) hi++;
      if (bus.FLUSH_TMO) break;
    end
    chk_cnt++;
    if (hi != TIMEOUT) $display("FAIL tmo_req_cycles: got %0d, required %0d", hi, TIMEOUT);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.FLUSH_TMO, bus.FLUSHFIFO, bus.DRAIN_REQ} !== 3'b110) $display("FAIL tmo_state: got tmo/ff/req=%b%b%b, required 110", bus.FLUSH_TMO, bus.FLUSHFIFO, bus.DRAIN_REQ);
    else pass_cnt++;
    bus.FLUSH_REQ = 1'b1;
    step();
    bus.FLUSH_REQ = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (!bus.FLUSH_TMO || !bus.FLUSHFIFO || bus.DRAIN_REQ || bus.FLUSH_DONE || bus.WORDS_FLUSHED != '0) err_held = 1'b0;
      step();
    end
    chk_cnt++;
    if (err_held !== 1'b1) $display("FAIL tmo_ignore_strobe: got held=%b, required 1", err_held);
    else pass_cnt++;
    #2 clr_n = 1'b0;
    #1;
    outs = {bus.DRAIN_REQ, bus.DRAIN_BE, bus.FLUSHFIFO, bus.FLUSH_DONE, bus.FLUSH_TMO, bus.WORDS_FLUSHED};
    chk_cnt++;
    if (outs !== '0) $display("FAIL tmo_async_clear: got %h, required 0", outs);
    else pass_cnt++;
    bus.FIFO_LEVEL = 0;
    #1 clr_n = 1'b1;
    step();
  endtask

  task automatic test_mid_reset();
    bit seen = 1'b0;
    bit quiet = 1'b1;
    bus.FIFO_LEVEL = 4; bus.BYTE_PTR = 0;
    bus.FLUSH_REQ = 1'b1;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      bus.FLUSH_REQ = 1'b0;
      seen = bus.DRAIN_REQ;
    end
    chk_cnt++;
    if (seen !== 1'b1) $display("FAIL mid_req_seen: got %b, required 1", seen);
    else pass_cnt++;
    #2 clr_n = 1'b0;
    #1;
    chk_cnt++;
    if ({bus.DRAIN_REQ, bus.FLUSHFIFO} !== 2'b00) $display("FAIL mid_async_reset: got req/ff=%b%b, required 00", bus.DRAIN_REQ, bus.FLUSHFIFO);
    else pass_cnt++;
    bus.FIFO_LEVEL = 0;
    #1 clr_n = 1'b1;
    bus.DRAIN_ACK = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.DRAIN_REQ || bus.FLUSHFIFO || bus.WORDS_FLUSHED != '0) quiet = 1'b0;
    end
    bus.DRAIN_ACK = 1'b0;
    chk_cnt++;
    if (quiet !== 1'b1) $display("FAIL idle_ack_ignored: got quiet=%b, required 1", quiet);
    else pass_cnt++;
  endtask

  initial begin
    clr_n          = 1'b0;
    bus.FLUSH_REQ  = 1'b0;
    bus.DMAENA     = 1'b1;
    bus.FIFO_LEVEL = '0;
    bus.BYTE_PTR   = '0;
    bus.DRAIN_ACK  = 1'b0;
    test_reset();
    test_full_drain();
    test_partial();
    test_empty();
    test_random();
    test_abort();
    test_back_to_back();
    test_saturate();
    test_timeout();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/flush_sequencer.md
Name: flush_sequencer

Overview:
- Parametrised successor to the single-bit FLUSHFIFO latch. Instead of only flagging a flush, it actively drains the DMA FIFO.
- On a flush strobe it sets FLUSHFIFO, then issues one bus drain request per full FIFO entry. A trailing partial entry is drained with per-lane byte enables.
- Handles timeout, abort and completion reporting.
- Sits between the register decode (flush strobe) and the DMA bus master / FIFO pointer logic.

Parameters:
- WIDTH, 32, FIFO entry / bus width in bits; must be a multiple of 8, minimum 16.
- DEPTH, 8, FIFO depth in entries; power of two.
- TIMEOUT, 255, max cycles to wait for DRAIN_ACK per request; 1..2^16-1.
- LVL_W, $clog2(DEPTH)+1, width of FIFO_LEVEL and WORDS_FLUSHED.
- BP_W, $clog2(WIDTH/8), width of BYTE_PTR.

Ports:
- CLK  in  1  nCPUCLK domain clock; all logic on rising edge.
- CLR_FLUSHFIFO  in  1  reset, asynchronous, active-low (asserted on STOPFLUSH or system reset).
- FLUSH_REQ  in  1  single-cycle flush strobe from register decode.
- DMAENA  in  1  DMA enabled.
- FIFO_LEVEL  in  LVL_W  count of complete entries in the FIFO.
- BYTE_PTR  in  BP_W  valid bytes in the trailing partial entry; 0 = none.
- DRAIN_ACK  in  1  bus master accepted/completed the current drain request.
- DRAIN_REQ  out  1  request one drain bus cycle.
- DRAIN_BE  out  WIDTH/8  byte-lane enables for the current request; MSB = lane 0 (big-endian).
- FLUSHFIFO  out  1  flush in progress / status bit to ISTR.
- FLUSH_DONE  out  1  one-cycle completion pulse.
- FLUSH_TMO  out  1  sticky timeout error.
- WORDS_FLUSHED  out  LVL_W  drain requests completed in the current/last flush.

Behaviour:
- Reset (CLR_FLUSHFIFO=0, async): state IDLE; DRAIN_REQ=0, DRAIN_BE=0, FLUSHFIFO=0, FLUSH_DONE=0, FLUSH_TMO=0, WORDS_FLUSHED=0, timer=0. Reset is honoured mid-drain with no handshake completion.
- All outputs are registered.
- States: IDLE, ARM, REQ, WAIT, DONE, ERR.
- IDLE:
  - FLUSH_REQ=1 at edge n → next state ARM; FLUSHFIFO=1 and WORDS_FLUSHED=0 from edge n+1.
  - This applies regardless of DMAENA.
- ARM → REQ unconditionally (one-cycle settle for FIFO_LEVEL/BYTE_PTR).
- REQ, evaluated in priority order:
  1. DMAENA=0 → DONE (abort; no request issued).
  2. FIFO_LEVEL>0 → DRAIN_REQ=1, DRAIN_BE=all ones, next WAIT.
  3. FIFO_LEVEL=0 and BYTE_PTR≠0 → DRAIN_REQ=1, DRAIN_BE = top BYTE_PTR bits set (e.g. WIDTH=32, BYTE_PTR=3 → 4'b1110), next WAIT.
  4. Otherwise → DONE.
  - Resulting latency: the first DRAIN_REQ rises at edge n+3 after the FLUSH_REQ edge n.
- WAIT:
  - DRAIN_REQ and DRAIN_BE are held stable until DRAIN_ACK=1 is sampled.
  - On ack: DRAIN_REQ=0 and DRAIN_BE=0 next edge; WORDS_FLUSHED+1, saturating at 2^LVL_W-1; timer=0; next REQ.
  - REQ re-samples FIFO_LEVEL/BYTE_PTR, so one idle cycle separates consecutive requests.
  - DMAENA falling in WAIT does not abort; the handshake must complete first, and the abort is taken in the following REQ.
  - DRAIN_ACK outside WAIT is ignored.
- Timer: increments each WAIT cycle without ack. When the timer reaches TIMEOUT → ERR, DRAIN_REQ=0, FLUSH_TMO=1.
- ERR: FLUSHFIFO stays 1, no FLUSH_DONE; only reset exits. FLUSH_REQ is ignored.
- DONE: FLUSH_DONE=1 for exactly one cycle; FLUSHFIFO=0 on the same edge; next IDLE. WORDS_FLUSHED holds its value until the next accepted FLUSH_REQ.
- FLUSH_REQ in any state other than IDLE is ignored and not queued.
- Simultaneous DRAIN_ACK and timer expiry in the same cycle: the ack wins, and no error is raised.
- Width rule: DRAIN_BE = ~({(WIDTH/8){1'b1}} >> BYTE_PTR) for partial entries.
- A BYTE_PTR value ≥ WIDTH/8 is treated as a full entry.

Test Plan:
- WIDTH=32, FIFO_LEVEL=3 then decrementing on each ack, BYTE_PTR=0, ack 2 cycles after each req:
  - FLUSHFIFO rises at n+1 and DRAIN_REQ at n+3.
  - 3 requests, each with BE=4'hF.
  - Then FLUSH_DONE pulses for 1 cycle, FLUSHFIFO=0, WORDS_FLUSHED=3.
- FIFO_LEVEL=1, BYTE_PTR=2 (cleared after the partial ack) → two requests, BE=4'hF then 4'hC; WORDS_FLUSHED=2.
- FIFO_LEVEL=0, BYTE_PTR=0, FLUSH_REQ → no DRAIN_REQ; FLUSH_DONE at edge n+3; WORDS_FLUSHED=0.
- TIMEOUT=4, no ack → DRAIN_REQ drops after 4 WAIT cycles, FLUSH_TMO=1, FLUSHFIFO stays 1. A further FLUSH_REQ is ignored; asserting CLR_FLUSHFIFO low clears all outputs asynchronously.
- DMAENA dropped during WAIT with FIFO_LEVEL=4 → current request completes on ack; next REQ aborts to DONE; WORDS_FLUSHED=1.
- Second FLUSH_REQ mid-drain and reset mid-WAIT → second strobe has no effect; reset forces DRAIN_REQ=0 and FLUSHFIFO=0 immediately, without waiting for a clock edge.
